// File: rtl/des_pkg.sv
// Shared types and constants for the deserializer frame-alignment controller.
package des_pkg;

    typedef enum logic [2:0] {
        DES_IDLE   = 3'd0,
        DES_HUNT   = 3'd1,
        DES_SLIP   = 3'd2,
        DES_SETTLE = 3'd3,
        DES_VERIFY = 3'd4,
        DES_LOCKED = 3'd5
    } des_ctrl_state_t;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hBC;
    localparam int BUF_DEPTH = 2;
    localparam int IDX_W     = 8;
    localparam int GOOD_W    = 4;
    localparam int MISS_W    = 4;

    // Saturating increment shared by the good/miss header counters.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/des_frame_ctrl_if.sv
// Deserializer-side and downstream-stream signals of des_frame_ctrl.
interface des_frame_ctrl_if;
    logic [7:0] des_word;
    logic       des_word_valid;
    logic       des_enable;
    logic       des_reset;
    logic [7:0] word_out;
    logic       word_valid;
    logic       word_ready;

    modport master (
        input  des_word, des_word_valid, word_ready,
        output des_enable, des_reset, word_out, word_valid
    );

    modport slave (
        output des_word, des_word_valid, word_ready,
        input  des_enable, des_reset, word_out, word_valid
    );
endinterface

// File: rtl/des_ctrl_buf.sv
// Two-entry payload FIFO with flush and a sticky drop flag.
module des_ctrl_buf
    import des_pkg::*;
(
    input  logic       clock_40,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop_ready,
    output logic [7:0] head_data,
    output logic       not_empty,
    output logic       overflow
);

    logic [7:0] mem [BUF_DEPTH];
    logic       rd_ptr;
    logic       wr_ptr;
    logic [1:0] count;
    logic       full;
    logic       pop;
    logic       push_ok;

    assign not_empty = (count != 2'd0);
    assign full      = (count == 2'(BUF_DEPTH));
    assign pop       = not_empty && pop_ready;
    // A pop in the same cycle frees the slot, so a full buffer can still take the push.
    assign push_ok   = push && (!full || pop);
    assign head_data = not_empty ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clock_40) begin
        if (reset) begin
            mem[0]   <= 8'h00;
            mem[1]   <= 8'h00;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            overflow <= 1'b0;
        end else begin
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
            if (flush) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (push_ok) begin
                    mem[wr_ptr] <= push_data;
                    wr_ptr      <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                count <= count + {1'b0, push_ok} - {1'b0, pop};
            end
        end
    end

endmodule

// File: rtl/des_frame_ctrl.sv
// Frame-alignment controller: bit-slips the deserializer onto the sync header and streams payload.
// Optional DES_FRAME_CTRL_STATS_EN adds err_count, a saturating header-mismatch counter.
module des_frame_ctrl
    import des_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD    = SYNC_WORD_DEFAULT,
    parameter int         FRAME_LEN    = 16,
    parameter int         LOCK_COUNT   = 4,
    parameter int         UNLOCK_COUNT = 3
) (
    input  logic              clock_40,
    input  logic              reset,
    input  logic              run,
    des_frame_ctrl_if.master  bus,
    output logic              locked,
    output logic [2:0]        slip_count,
    output logic              overflow
`ifdef DES_FRAME_CTRL_STATS_EN
    ,
    output logic [15:0]       err_count
`endif
);

    localparam logic [2:0] ST_IDLE   = DES_IDLE;
    localparam logic [2:0] ST_HUNT   = DES_HUNT;
    localparam logic [2:0] ST_SLIP   = DES_SLIP;
    localparam logic [2:0] ST_SETTLE = DES_SETTLE;
    localparam logic [2:0] ST_VERIFY = DES_VERIFY;
    localparam logic [2:0] ST_LOCKED = DES_LOCKED;

    localparam logic [IDX_W-1:0]  IDX_LAST    = IDX_W'(FRAME_LEN - 1);
    localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0] MISS_TARGET = MISS_W'(UNLOCK_COUNT);

    logic [2:0]        state;
    logic [IDX_W-1:0]  word_idx;
    logic [IDX_W-1:0]  idx_next;
    logic [GOOD_W-1:0] good;
    logic [GOOD_W-1:0] good_inc;
    logic [MISS_W-1:0] miss;
    logic [MISS_W-1:0] miss_inc;
    logic              is_sync;
    logic              header_slot;
    logic              push;

    assign is_sync     = (bus.des_word == SYNC_WORD);
    assign header_slot = (word_idx == '0);
    assign idx_next    = (word_idx == IDX_LAST) ? '0 : word_idx + IDX_W'(1);
    assign good_inc    = sat_inc4(good);
    assign miss_inc    = sat_inc4(miss);
    assign push        = run && (state == ST_LOCKED) && bus.des_word_valid && !header_slot;

    assign bus.des_enable = (state != ST_IDLE) && (state != ST_SLIP);
    assign bus.des_reset  = (state == ST_IDLE);
    assign locked         = (state == ST_LOCKED);

    // Alignment state machine; a word in SETTLE may straddle the old boundary so it is dropped.
    always_ff @(posedge clock_40) begin
        if (reset) begin
            state      <= ST_IDLE;
            word_idx   <= '0;
            good       <= '0;
            miss       <= '0;
            slip_count <= 3'd0;
        end else if (!run) begin
            state    <= ST_IDLE;
            word_idx <= '0;
            good     <= '0;
            miss     <= '0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_HUNT;
                ST_HUNT: begin
                    if (bus.des_word_valid) begin
                        if (is_sync) begin
                            word_idx <= IDX_W'(1);
                            good     <= GOOD_W'(1);
                            miss     <= '0;
                            state    <= (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
                        end else begin
                            state <= ST_SLIP;
                        end
                    end
                end
                ST_SLIP: begin
                    slip_count <= slip_count + 3'd1;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (bus.des_word_valid) begin
                        state <= ST_HUNT;
                    end
                end
                ST_VERIFY: begin
                    if (bus.des_word_valid) begin
                        word_idx <= idx_next;
                        if (header_slot) begin
                            if (is_sync) begin
                                good <= good_inc;
                                if (good_inc == GOOD_TARGET) begin
                                    miss  <= '0;
                                    state <= ST_LOCKED;
                                end
                            end else begin
                                state <= ST_SLIP;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    if (bus.des_word_valid) begin
                        word_idx <= idx_next;
                        if (header_slot) begin
                            if (is_sync) begin
                                miss <= '0;
                            end else begin
                                miss <= miss_inc;
                                if (miss_inc == MISS_TARGET) begin
                                    state <= ST_HUNT;
                                end
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    des_ctrl_buf u_buf (
        .clock_40  (clock_40),
        .reset     (reset),
        .flush     (!run),
        .push      (push),
        .push_data (bus.des_word),
        .pop_ready (bus.word_ready),
        .head_data (bus.word_out),
        .not_empty (bus.word_valid),
        .overflow  (overflow)
    );

`ifdef DES_FRAME_CTRL_STATS_EN
    logic hdr_err;

    assign hdr_err = run && bus.des_word_valid && header_slot && !is_sync &&
                     ((state == ST_VERIFY) || (state == ST_LOCKED));

    // Survives run=0 on purpose so errors from earlier sessions stay visible.
    always_ff @(posedge clock_40) begin
        if (reset) begin
            err_count <= 16'h0000;
        end else if (hdr_err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_des_frame_ctrl.sv
// Directed bench for des_frame_ctrl; build with DES_FRAME_CTRL_STATS_EN to also cover err_count.
module tb_des_frame_ctrl;
    import des_pkg::*;

    typedef struct {
        logic [7:0] hdr;
        logic       exp_locked;
    } vec_t;

    logic        clock_40 = 1'b0;
    logic        reset;
    logic        run;
    logic        locked;
    logic [2:0]  slip_count;
    logic        overflow;
`ifdef DES_FRAME_CTRL_STATS_EN
    logic [15:0] err_count;
`endif

    des_frame_ctrl_if bus ();

    des_frame_ctrl dut (
        .clock_40   (clock_40),
        .reset      (reset),
        .run        (run),
        .bus        (bus),
        .locked     (locked),
        .slip_count (slip_count),
        .overflow   (overflow)
`ifdef DES_FRAME_CTRL_STATS_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clock_40 = ~clock_40;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] rx [$];

    // Records every word actually handed over downstream.
    always @(negedge clock_40) begin
        if (bus.word_valid === 1'b1 && bus.word_ready === 1'b1) begin
            rx.push_back(bus.word_out);
        end
    end

    task automatic tick();
        @(posedge clock_40);
        #1;
    endtask

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] payload(input int f, input int j);
        return {4'(f), 4'(j)};
    endfunction

    task automatic send_word(input logic [7:0] w);
        bus.des_word       = w;
        bus.des_word_valid = 1'b1;
        tick();
        bus.des_word_valid = 1'b0;
    endtask

    task automatic send_payload(input int f, input int first_j);
        for (int j = first_j; j < 16; j++) begin
            send_word(payload(f, j));
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input int f);
        send_word(v.hdr);
        check_output("lock_table", {15'd0, locked}, {15'd0, v.exp_locked});
        send_payload(f, 1);
    endtask

    // Reset, start, and deliver three aligned frames; the caller sends the 4th header.
    task automatic lock_up(input logic ready);
        bus.word_ready     = ready;
        bus.des_word_valid = 1'b0;
        run   = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        for (int f = 0; f < 3; f++) begin
            send_word(8'hBC);
            send_payload(f, 1);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_des_enable"}, {15'd0, bus.des_enable}, 16'd0);
        check_output({tag, "_des_reset"},  {15'd0, bus.des_reset},  16'd1);
        check_output({tag, "_word_valid"}, {15'd0, bus.word_valid}, 16'd0);
        check_output({tag, "_word_out"},   {8'd0, bus.word_out},    16'd0);
        check_output({tag, "_locked"},     {15'd0, locked},         16'd0);
        check_output({tag, "_slip_count"}, {13'd0, slip_count},     16'd0);
        check_output({tag, "_overflow"},   {15'd0, overflow},       16'd0);
    endtask

    initial begin
        vec_t       loss_vecs [6];
        logic [7:0] exp_q [$];
        logic [15:0] pat;
        logic [15:0] act;
        int         pos;
        int         low_len;
        int         pulses;
        int         s;

        loss_vecs[0] = '{8'h00, 1'b1};
        loss_vecs[1] = '{8'h00, 1'b1};
        loss_vecs[2] = '{8'hBC, 1'b1};
        loss_vecs[3] = '{8'h00, 1'b1};
        loss_vecs[4] = '{8'h00, 1'b1};
        loss_vecs[5] = '{8'h00, 1'b0};

        bus.des_word       = 8'h00;
        bus.des_word_valid = 1'b0;
        bus.word_ready     = 1'b1;
        run   = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        check_reset_values("por");
        reset = 1'b0;
        tick();
        check_output("idle_hold_des_reset", {15'd0, bus.des_reset}, 16'd1);

        // Clean lock on an aligned stream, then in-order delivery of 4 frames of payload.
        lock_up(1'b1);
        check_output("pre_lock", {15'd0, locked}, 16'd0);
        rx.delete();
        send_word(8'hBC);
        check_output("lock_latency", {15'd0, locked}, 16'd1);
        send_word(payload(3, 1));
        check_output("push_latency_valid", {15'd0, bus.word_valid}, 16'd1);
        check_output("push_latency_data", {8'd0, bus.word_out}, {8'd0, payload(3, 1)});
        send_payload(3, 2);
        for (int f = 4; f < 7; f++) begin
            send_word(8'hBC);
            send_payload(f, 1);
        end
        tick();
        tick();
        exp_q.delete();
        for (int f = 3; f < 7; f++) begin
            for (int j = 1; j < 16; j++) begin
                exp_q.push_back(payload(f, j));
            end
        end
        check_output("rx_count", 16'(rx.size()), 16'd60);
        for (int i = 0; i < 60; i++) begin
            act = (i < rx.size()) ? {8'd0, rx[i]} : 16'hDEAD;
            check_output("rx_order", act, {8'd0, exp_q[i]});
        end

        // Loss of lock: two misses then a good header hold lock, three misses drop it.
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(loss_vecs[k], 7 + k);
        end

        // Stream 3 bits off alignment, all-header pattern; the bench models the bit slips.
        bus.word_ready = 1'b1;
        run   = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        pat     = 16'hBCBC;
        pos     = 5;
        low_len = 0;
        pulses  = 0;
        for (int c = 0; c < 400 && locked !== 1'b1; c++) begin
            if (bus.des_enable === 1'b0) begin
                pos++;
                low_len++;
                bus.des_word_valid = 1'b0;
            end else begin
                if (low_len > 0) begin
                    check_output("slip_pulse_len", 16'(low_len), 16'd1);
                    pulses++;
                end
                low_len = 0;
                s = pos % 8;
                bus.des_word       = pat[15 - s -: 8];
                bus.des_word_valid = 1'b1;
                pos += 8;
            end
            tick();
        end
        bus.des_word_valid = 1'b0;
        check_output("misalign_locked", {15'd0, locked}, 16'd1);
        check_output("misalign_slip_count", {13'd0, slip_count}, 16'd3);
        check_output("misalign_pulses", 16'(pulses), 16'd3);

        // Backpressure: two words held, three dropped.
        lock_up(1'b0);
        send_word(8'hBC);
        check_output("bp_locked", {15'd0, locked}, 16'd1);
        for (int k = 1; k <= 5; k++) begin
            send_word(payload(3, k));
            check_output("bp_valid", {15'd0, bus.word_valid}, 16'd1);
            check_output("bp_hold", {8'd0, bus.word_out}, {8'd0, payload(3, 1)});
            check_output("bp_overflow", {15'd0, overflow}, (k >= 3) ? 16'd1 : 16'd0);
        end
        rx.delete();
        bus.word_ready = 1'b1;
        tick();
        tick();
        tick();
        check_output("bp_rx_count", 16'(rx.size()), 16'd2);
        act = (rx.size() > 0) ? {8'd0, rx[0]} : 16'hDEAD;
        check_output("bp_rx0", act, {8'd0, payload(3, 1)});
        act = (rx.size() > 1) ? {8'd0, rx[1]} : 16'hDEAD;
        check_output("bp_rx1", act, {8'd0, payload(3, 2)});
        check_output("bp_overflow_sticky", {15'd0, overflow}, 16'd1);

        // Reset mid-frame with a word buffered and overflow set.
        bus.word_ready = 1'b0;
        send_word(payload(3, 6));
        check_output("pre_reset_valid", {15'd0, bus.word_valid}, 16'd1);
        reset = 1'b1;
        tick();
        check_reset_values("midframe_reset");
        reset = 1'b0;

        // Full buffer with simultaneous pop and push.
        lock_up(1'b0);
        send_word(8'hBC);
        send_word(payload(3, 1));
        send_word(payload(3, 2));
        rx.delete();
        bus.word_ready = 1'b1;
        send_word(payload(3, 3));
        check_output("popush_overflow", {15'd0, overflow}, 16'd0);
        check_output("popush_head", {8'd0, bus.word_out}, {8'd0, payload(3, 2)});
        tick();
        tick();
        tick();
        check_output("popush_rx_count", 16'(rx.size()), 16'd3);
        for (int i = 0; i < 3; i++) begin
            act = (i < rx.size()) ? {8'd0, rx[i]} : 16'hDEAD;
            check_output("popush_rx", act, {8'd0, payload(3, i + 1)});
        end

        // run=0 returns to IDLE and flushes; des_reset drops the cycle after leaving IDLE.
        lock_up(1'b0);
        send_word(8'hBC);
        send_word(payload(3, 1));
        check_output("run_pre_valid", {15'd0, bus.word_valid}, 16'd1);
        run = 1'b0;
        tick();
        check_output("run_off_des_reset", {15'd0, bus.des_reset}, 16'd1);
        check_output("run_off_des_enable", {15'd0, bus.des_enable}, 16'd0);
        check_output("run_off_locked", {15'd0, locked}, 16'd0);
        check_output("run_off_flush", {15'd0, bus.word_valid}, 16'd0);
        run = 1'b1;
        tick();
        check_output("run_on_des_reset", {15'd0, bus.des_reset}, 16'd0);
        check_output("run_on_des_enable", {15'd0, bus.des_enable}, 16'd1);
        check_output("run_on_empty", {15'd0, bus.word_valid}, 16'd0);

`ifdef DES_FRAME_CTRL_STATS_EN
        // Five header mismatches spread so lock is never lost.
        lock_up(1'b1);
        send_word(8'hBC);
        send_payload(3, 1);
        for (int f = 4; f < 11; f++) begin
            send_word((f == 6 || f == 9) ? 8'hBC : 8'h00);
            send_payload(f, 1);
        end
        check_output("stats_locked", {15'd0, locked}, 16'd1);
        check_output("stats_err_count", err_count, 16'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
